// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and
// the fill value returned by an access abandoned on timeout.
package mem_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DBUSY = 2'd1;
   localparam logic [1:0] ST_IBUSY = 2'd2;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Ack-timeout counter for the memory arbiter: counts busy cycles without ack
// and flags expiry on the cycle the count reaches TIMEOUT_CYC.
module mem_arb_watchdog
#(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic cnt_i,
   output logic expire_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Expiry fires on the waiting cycle whose increment would reach TIMEOUT_CYC.
   assign expire_o = cnt_i & (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory port between IF fetches and MEM data accesses,
// data first, stalling the pipeline until both finish. MEM_ARB_WATCHDOG_EN adds an ack timeout.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_data_o,
   input  logic        mem_rd_i,
   input  logic        mem_wr_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   output logic [31:0] mem_rdata_o,
   output logic        ext_req_o,
   output logic        ext_we_o,
   output logic [31:0] ext_addr_o,
   output logic [31:0] ext_wdata_o,
   input  logic        ext_ack_i,
   input  logic [31:0] ext_rdata_i,
   output logic        stall_o,
   output logic        err_o
);

   logic [1:0]  state_q, state_d;
   logic        d_done_q, d_done_d;
   logic        i_done_q, i_done_d;
   logic [31:0] if_data_q, if_data_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;
   logic        d_pend, i_pend, busy, complete, timeout;
   logic [31:0] fill_data;

   if (TIMEOUT_CYC == 0) begin : g_bad_timeout
      $error("mem_arbiter: TIMEOUT_CYC must be at least 1");
   end

`ifdef MEM_ARB_WATCHDOG_EN
   logic err_q, err_d;
   logic wd_clr, wd_cnt;

   assign wd_clr = (state_q == ST_IDLE) | complete;
   assign wd_cnt = busy & ~ext_ack_i;

   mem_arb_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (wd_clr),
      .cnt_i    (wd_cnt),
      .expire_o (timeout)
   );

   assign err_d = err_q | timeout;
   assign err_o = err_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

   assign d_pend    = (mem_rd_i | mem_wr_i) & ~d_done_q;
   assign i_pend    = if_req_i & ~i_done_q;
   assign stall_o   = d_pend | i_pend;
   assign busy      = (state_q != ST_IDLE);
   assign complete  = busy & (ext_ack_i | timeout);
   assign fill_data = ext_ack_i ? ext_rdata_i : TIMEOUT_DATA;

   always_comb begin
      state_d     = state_q;
      d_done_d    = d_done_q;
      i_done_d    = i_done_q;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (d_pend) begin
               state_d = ST_DBUSY;
            end else if (i_pend) begin
               state_d = ST_IBUSY;
            end else begin
               // Nothing outstanding: the pipeline advances on this edge.
               d_done_d = 1'b0;
               i_done_d = 1'b0;
            end
         end
         ST_DBUSY: begin
            if (complete) begin
               d_done_d = 1'b1;
               if (mem_rd_i & ~mem_wr_i) begin
                  mem_rdata_d = fill_data;
               end
               state_d = i_pend ? ST_IBUSY : ST_IDLE;
            end
         end
         ST_IBUSY: begin
            if (complete) begin
               i_done_d  = 1'b1;
               if_data_d = fill_data;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ext_req_o   = busy;
      ext_we_o    = 1'b0;
      ext_addr_o  = '0;
      ext_wdata_o = '0;
      if (state_q == ST_DBUSY) begin
         ext_we_o    = mem_wr_i;
         ext_addr_o  = mem_addr_i;
         ext_wdata_o = mem_wdata_i;
      end else if (state_q == ST_IBUSY) begin
         ext_addr_o  = if_addr_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         d_done_q    <= 1'b0;
         i_done_q    <= 1'b0;
         if_data_q   <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         d_done_q    <= d_done_d;
         i_done_q    <= i_done_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign if_data_o   = if_data_q;
   assign mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: each pipeline cycle is expanded into the
// expected per-clock port activity and checked every cycle.
module tb_mem_arbiter;

   localparam int TB_TIMEOUT = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_data_o;
   logic        mem_rd_i;
   logic        mem_wr_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [31:0] mem_rdata_o;
   logic        ext_req_o;
   logic        ext_we_o;
   logic [31:0] ext_addr_o;
   logic [31:0] ext_wdata_o;
   logic        ext_ack_i;
   logic [31:0] ext_rdata_i;
   logic        stall_o;
   logic        err_o;

   always #5 clk_i = ~clk_i;

   mem_arbiter #(
      .TIMEOUT_CYC (TB_TIMEOUT)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_data_o   (if_data_o),
      .mem_rd_i    (mem_rd_i),
      .mem_wr_i    (mem_wr_i),
      .mem_addr_i  (mem_addr_i),
      .mem_wdata_i (mem_wdata_i),
      .mem_rdata_o (mem_rdata_o),
      .ext_req_o   (ext_req_o),
      .ext_we_o    (ext_we_o),
      .ext_addr_o  (ext_addr_o),
      .ext_wdata_o (ext_wdata_o),
      .ext_ack_i   (ext_ack_i),
      .ext_rdata_i (ext_rdata_i),
      .stall_o     (stall_o),
      .err_o       (err_o)
   );

   typedef struct {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          wchk;
      logic        stall;
      logic [31:0] ifd;
      logic [31:0] mrd;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_ifd;
   logic [31:0] exp_mrd;
   logic        exp_err;
   int          n_cmp = 0;
   int          n_err = 0;
   int          stall_cnt = 0;
   logic [31:0] addr_log[$];
   logic        we_log[$];
   logic [31:0] wd_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_exp(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit wchk, input logic stall);
      exp_t e;
      e.req   = req;
      e.we    = we;
      e.addr  = addr;
      e.wdata = wdata;
      e.wchk  = wchk;
      e.stall = stall;
      e.ifd   = exp_ifd;
      e.mrd   = exp_mrd;
      e.err   = exp_err;
      exp_q.push_back(e);
   endtask

   // One pipeline cycle: an idle cycle, the data access, the fetch, then the release cycle.
   task automatic run_op(input logic rd, input logic wr, input logic fe,
                         input logic [31:0] maddr, input logic [31:0] wdat,
                         input logic [31:0] iaddr, input logic [31:0] drd,
                         input logic [31:0] ird, input int dd, input int di, input bit d_to);
      mem_rd_i    = rd;
      mem_wr_i    = wr;
      if_req_i    = fe;
      mem_addr_i  = maddr;
      mem_wdata_i = wdat;
      if_addr_i   = iaddr;
      ext_ack_i   = 1'b0;
      ext_rdata_i = $urandom;
      push_exp(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, rd | wr | fe);
      step();
      if (rd | wr | fe) begin
         if (rd | wr) begin
            int n = d_to ? TB_TIMEOUT : dd + 1;
            for (int k = 0; k < n; k++) begin
               ext_ack_i   = (k == n - 1) && !d_to;
               ext_rdata_i = ext_ack_i ? drd : $urandom;
               push_exp(1'b1, wr, maddr, wdat, 1'b1, 1'b1);
               step();
            end
            if (rd & ~wr) exp_mrd = d_to ? 32'hDEADBEEF : drd;
            if (d_to) exp_err = 1'b1;
         end
         if (fe) begin
            for (int k = 0; k <= di; k++) begin
               ext_ack_i   = (k == di);
               ext_rdata_i = ext_ack_i ? ird : $urandom;
               push_exp(1'b1, 1'b0, iaddr, 32'h0, 1'b0, 1'b1);
               step();
            end
            exp_ifd = ird;
         end
         ext_ack_i = 1'b0;
         push_exp(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         step();
      end
   endtask

   initial begin : compare
      exp_t cur;
      forever begin
         @(negedge clk_i);
         if (stall_o) stall_cnt++;
         if (ext_req_o) begin
            addr_log.push_back(ext_addr_o);
            we_log.push_back(ext_we_o);
            wd_log.push_back(ext_wdata_o);
         end
         if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("ext_req_o", 32'(ext_req_o), 32'(cur.req));
            chk("ext_we_o", 32'(ext_we_o), 32'(cur.we));
            chk("ext_addr_o", ext_addr_o, cur.addr);
            if (cur.wchk) chk("ext_wdata_o", ext_wdata_o, cur.wdata);
            chk("stall_o", 32'(stall_o), 32'(cur.stall));
            chk("if_data_o", if_data_o, cur.ifd);
            chk("mem_rdata_o", mem_rdata_o, cur.mrd);
            chk("err_o", 32'(err_o), 32'(cur.err));
         end
      end
   end

   initial begin : time_limit
      #2000000;
      $display("FAIL sim_timeout: got no finish, expected finish before %0t", $time);
      $fatal(1, "simulation time limit");
   end

   initial begin : main
      int s0;
      int a0;
      rst_i       = 1'b1;
      if_req_i    = 1'b0;
      if_addr_i   = '0;
      mem_rd_i    = 1'b0;
      mem_wr_i    = 1'b0;
      mem_addr_i  = '0;
      mem_wdata_i = '0;
      ext_ack_i   = 1'b0;
      ext_rdata_i = '0;
      exp_ifd     = '0;
      exp_mrd     = '0;
      exp_err     = 1'b0;

      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_ext_req", 32'(ext_req_o), 32'h0);
      chk("rst_ext_we", 32'(ext_we_o), 32'h0);
      chk("rst_ext_addr", ext_addr_o, 32'h0);
      chk("rst_ext_wdata", ext_wdata_o, 32'h0);
      chk("rst_stall", 32'(stall_o), 32'h0);
      chk("rst_if_data", if_data_o, 32'h0);
      chk("rst_mem_rdata", mem_rdata_o, 32'h0);
      chk("rst_err", 32'(err_o), 32'h0);
      rst_i = 1'b0;
      step();

      s0 = stall_cnt;
      run_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h10, 32'h0, 32'h8C220004, 0, 0, 1'b0);
      chk("fetch_stall_cycles", 32'(stall_cnt - s0), 32'd2);
      chk("fetch_if_data", if_data_o, 32'h8C220004);

      s0 = stall_cnt;
      a0 = addr_log.size();
      run_op(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 32'h14, 32'h11112222, 32'hAABBCCDD, 3, 3, 1'b0);
      chk("ldf_stall_cycles", 32'(stall_cnt - s0), 32'd9);
      chk("ldf_busy_cycles", 32'(addr_log.size() - a0), 32'd8);
      chk("ldf_first_addr", addr_log[a0], 32'h20);
      chk("ldf_last_addr", addr_log[a0 + 7], 32'h14);
      chk("ldf_mem_rdata", mem_rdata_o, 32'h11112222);
      chk("ldf_if_data", if_data_o, 32'hAABBCCDD);

      a0 = addr_log.size();
      run_op(1'b1, 1'b1, 1'b0, 32'h30, 32'h55, 32'h0, 32'h99999999, 32'h0, 1, 0, 1'b0);
      chk("rw_busy_cycles", 32'(addr_log.size() - a0), 32'd2);
      chk("rw_we", 32'(we_log[a0]), 32'h1);
      chk("rw_wdata", wd_log[a0], 32'h55);
      chk("rw_mem_rdata_kept", mem_rdata_o, 32'h11112222);

      a0 = addr_log.size();
      run_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h100, 32'h0, 32'h01010101, 0, 0, 1'b0);
      run_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h104, 32'h0, 32'h02020202, 0, 0, 1'b0);
      chk("b2b_fetch_count", 32'(addr_log.size() - a0), 32'd2);
      chk("b2b_first_addr", addr_log[a0], 32'h100);
      chk("b2b_second_addr", addr_log[a0 + 1], 32'h104);
      chk("b2b_if_data", if_data_o, 32'h02020202);

      for (int i = 0; i < 200; i++) begin
         run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
      end

`ifdef MEM_ARB_WATCHDOG_EN
      s0 = stall_cnt;
      run_op(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 32'h204, 32'h12345678, 32'h0BADF00D, 0, 0, 1'b1);
      chk("wd_stall_cycles", 32'(stall_cnt - s0), 32'd6);
      chk("wd_mem_rdata", mem_rdata_o, 32'hDEADBEEF);
      chk("wd_err", 32'(err_o), 32'h1);
      run_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h208, 32'h0, 32'h33334444, 1, 1, 1'b0);
      chk("wd_err_sticky", 32'(err_o), 32'h1);
`endif

      run_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0);
      chk("model_drained", 32'(exp_q.size()), 32'h0);

      mem_rd_i   = 1'b1;
      mem_wr_i   = 1'b0;
      if_req_i   = 1'b0;
      mem_addr_i = 32'h40;
      ext_ack_i  = 1'b0;
      step();
      chk("rst_mid_req_before", 32'(ext_req_o), 32'h1);
      chk("rst_mid_addr_before", ext_addr_o, 32'h40);
      chk("rst_mid_if_data_before", if_data_o, exp_ifd);
      #2;
      rst_i = 1'b1;
      #1;
      chk("rst_mid_req", 32'(ext_req_o), 32'h0);
      chk("rst_mid_we", 32'(ext_we_o), 32'h0);
      chk("rst_mid_addr", ext_addr_o, 32'h0);
      chk("rst_mid_if_data", if_data_o, 32'h0);
      chk("rst_mid_mem_rdata", mem_rdata_o, 32'h0);
      chk("rst_mid_err", 32'(err_o), 32'h0);
      mem_rd_i   = 1'b0;
      mem_addr_i = '0;
      #1;
      chk("rst_mid_stall", 32'(stall_o), 32'h0);
      step();
      rst_i   = 1'b0;
      exp_ifd = '0;
      exp_mrd = '0;
      exp_err = 1'b0;
      step();
      step();
      chk("post_rst_stall", 32'(stall_o), 32'h0);
      chk("post_rst_req", 32'(ext_req_o), 32'h0);
      chk("post_rst_if_data", if_data_o, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
